// File: rtl/vector_fetch.sv
// Address-FIFO consumer: pops a vector address, issues a single-beat read, pushes the word into the vector FIFO.
// Optional WAIT timeout is compiled in with `define VECTOR_FETCH_TIMEOUT_EN.
module vector_fetch #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_program,
  input  logic              addr_fifo_empty,
  input  logic [ADDR_W-1:0] addr_fifo_dout,
  output logic              addr_fifo_rd,
  output logic [ADDR_W-1:0] master_addr,
  output logic              master_rd,
  input  logic              master_wait,
  input  logic [DATA_W-1:0] master_data_in,
  input  logic              master_data_in_val,
  input  logic              vctr_fifo_full,
  output logic [DATA_W-1:0] vctr_fifo_din,
  output logic              vctr_fifo_wr,
  output logic              busy,
  output logic [31:0]       fetch_cnt,
  output logic [1:0]        err_flags
);

  // state | meaning
  // IDLE  | nothing in flight, waiting for run_program and a queued address
  // POP   | addr_fifo_rd high for this one cycle
  // LATCH | addr_fifo_dout valid, captured into master_addr
  // ISSUE | master_rd held with stable address until accepted
  // WAIT  | one read outstanding, waiting for the data beat
  // PUSH  | captured word held on vctr_fifo_din until the vector FIFO has room
  typedef enum logic [2:0] {IDLE, POP, LATCH, ISSUE, WAIT, PUSH} state_t;

  state_t state;
  logic   err_spur;
  logic   err_timeout;

  assign err_flags = {err_timeout, err_spur};

`ifdef VECTOR_FETCH_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr_fifo_rd  <= 1'b0;
      master_addr   <= '0;
      master_rd     <= 1'b0;
      vctr_fifo_din <= '0;
      vctr_fifo_wr  <= 1'b0;
      busy          <= 1'b0;
      fetch_cnt     <= '0;
      err_spur      <= 1'b0;
`ifdef VECTOR_FETCH_TIMEOUT_EN
      err_timeout   <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      addr_fifo_rd <= 1'b0;
      vctr_fifo_wr <= 1'b0;
      // a data beat is only meaningful while a read is outstanding
      if (master_data_in_val && (state != WAIT)) err_spur <= 1'b1;
      case (state)
        IDLE: begin
          if (run_program && !addr_fifo_empty) begin
            state        <= POP;
            addr_fifo_rd <= 1'b1;
            busy         <= 1'b1;
          end
        end
        POP: state <= LATCH;
        LATCH: begin
          master_addr <= addr_fifo_dout;
          master_rd   <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (!master_wait) begin
            master_rd <= 1'b0;
            state     <= WAIT;
`ifdef VECTOR_FETCH_TIMEOUT_EN
            wait_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        WAIT: begin
          if (master_data_in_val) begin
            vctr_fifo_din <= master_data_in;
            state         <= PUSH;
          end
`ifdef VECTOR_FETCH_TIMEOUT_EN
          else if (wait_cnt == '0) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
`endif
        end
        PUSH: begin
          if (!vctr_fifo_full) begin
            vctr_fifo_wr <= 1'b1;
            fetch_cnt    <= fetch_cnt + 32'd1;
            if (run_program && !addr_fifo_empty) begin
              state        <= POP;
              addr_fifo_rd <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
